alu_inst_enc: RTL and testbench
===============================

Name: alu_inst_enc

Overview:
- Inverse of the ALU decoder: turns an ALU operation request into a 32-bit MIPS instruction word (opcode/funct per Opcode.vh, ALUop codes per ALUop.vh).
- Buffers the encoded words in a small FIFO.
- Feeds the self-test instruction generator and instruction memory loader with valid/ready handshakes on both sides.
- Unencodable requests are dropped and counted.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of the saturating illegal-request counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request
req_alu_op  input  4  ALUop code (ALUop.vh)
req_use_imm  input  1  1 = immediate/shamt form
req_rs  input  5  source register; shift-amount register for variable shifts
req_rt  input  5  second source; shifted value for shifts
req_rd  input  5  destination register
req_imm  input  16  immediate; [4:0] = shamt for immediate shifts
inst_valid  output  1  encoded word available
inst_ready  input  1  consumer takes word
inst  output  32  encoded instruction word
count  output  $clog2(DEPTH)+1  FIFO occupancy
err  output  1  one-cycle pulse: illegal request accepted and dropped
err_cnt  output  CNT_W  saturating count of dropped requests

Behaviour:
- Reset (async, rst=1): FIFO pointers and count=0, inst_valid=0, inst=0, err=0, err_cnt=0, req_ready=1 once rst deasserts. Asserting rst mid-operation discards all buffered words immediately.
- Accept: req_valid & req_ready at a clk edge.
- req_ready = (count != DEPTH). No pass-through when full, even if popping the same cycle.
- Encoding, R-type, use_imm=0: op=RTYPE, rs=req_rs, rt=req_rt, rd=req_rd, shamt=0.
  - funct: ALU_ADDU->ADDU, ALU_SUBU->SUBU, AND, OR, XOR, NOR, ALU_SLT->SLT, ALU_SLTU->SLTU.
  - Shifts: ALU_SLL->SLLV, ALU_SRL->SRLV, ALU_SRA->SRAV.
- Encoding, immediate shifts, use_imm=1 with ALU_SLL/SRL/SRA: op=RTYPE, rs=0, rt=req_rt, rd=req_rd, shamt=req_imm[4:0], funct SLL/SRL/SRA.
- Encoding, I-type, use_imm=1: rs=req_rs, rt field=req_rd, imm=req_imm.
  - Opcodes: ALU_ADDU->ADDIU, ALU_SLT or ALU_SLTI->SLTI, ALU_SLTU->SLTIU, ALU_AND->ANDI, ALU_OR->ORI, ALU_XOR->XORI, ALU_LUI->LUI (rs forced 0).
- Illegal combinations:
  - SUBU or NOR with use_imm=1.
  - LUI or SLTI with use_imm=0.
  - ALU_XXX, or any undefined code.
- Illegal request handling: request is still accepted (handshake completes), nothing is pushed, err=1 the next cycle, err_cnt+1 saturating at all-ones.
- Latency: a word accepted at edge N is visible on inst with inst_valid=1 after edge N (registered storage, first-word fall-through), if the FIFO was empty.
- Pop: inst_valid & inst_ready. inst = head entry while inst_valid=1, else 32'h0.
- Simultaneous push and pop (not full): count unchanged, order preserved.
- Pointers wrap modulo DEPTH.
- inst_ready while empty: no effect.

Decomposition:
- Opcode/funct values and ALUop codes come from the existing Opcode.vh and ALUop.vh.
- Add to a shared header: instruction field position constants (OP 31:26, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNCT 5:0).
- One natural sub-module: alu_inst_enc_comb, a purely combinational encoder (request fields -> {legal, word32}).
- FIFO and counters live in the top module.

Test Plan:
- ADDU, use_imm=0, rs=1, rt=2, rd=3 -> inst=0x00221821 on the cycle after accept; count=1.
- ADDU, use_imm=1, rs=5, rd=9, imm=0x0010 -> inst=0x24A90010. Then LUI, use_imm=1, rd=7, imm=0xBEEF -> second word 0x3C07BEEF, in order.
- SLL, use_imm=1, rt=4, rd=6, imm=3 -> inst=0x000430C0.
- SUBU with use_imm=1 -> req_ready=1, no push, count stays 0, err pulses 1 cycle, err_cnt=1. Repeat 300 times with CNT_W=8 -> err_cnt holds 255.
- inst_ready=0, push 4 legal words -> req_ready=0 at count=4. Pulse inst_ready one cycle -> count=3, req_ready=1. Then drain -> words emerge in push order, inst_valid=0 and inst=0 after the last.
- With count=3, assert rst asynchronously between edges -> inst_valid=0, count=0, err_cnt=0 immediately. After release the next push appears normally.

Source files
------------

// File: rtl/alu_inst_enc_pkg.sv
// Shared encodings for the ALU-request-to-MIPS-instruction encoder:
// ALUop codes, opcode/funct values, instruction field positions and field packers.
package alu_inst_enc_pkg;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'h0,
        ALU_SUBU = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB,
        ALU_SLTI = 4'hC,
        ALU_XXX  = 4'hF
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        logic [31:0] w;
        w                     = '0;
        w[OP_HI:OP_LO]        = OP_RTYPE;
        w[RS_HI:RS_LO]        = rs;
        w[RT_HI:RT_LO]        = rt;
        w[RD_HI:RD_LO]        = rd;
        w[SHAMT_HI:SHAMT_LO]  = shamt;
        w[FUNCT_HI:FUNCT_LO]  = funct;
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        logic [31:0] w;
        w                 = '0;
        w[OP_HI:OP_LO]    = op;
        w[RS_HI:RS_LO]    = rs;
        w[RT_HI:RT_LO]    = rt;
        w[IMM_HI:IMM_LO]  = imm;
        return w;
    endfunction

endpackage

// File: rtl/alu_inst_enc_comb.sv
// Purely combinational encoder: ALU request fields -> {legal, 32-bit MIPS word}.
module alu_inst_enc_comb
    import alu_inst_enc_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic        use_imm,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic        legal,
    output logic [31:0] word
);

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (alu_op)
            ALU_ADDU: word = use_imm ? enc_i(OP_ADDIU, rs, rd, imm) : enc_r(rs, rt, rd, 5'd0, FN_ADDU);
            ALU_SUBU: if (use_imm) legal = 1'b0; else word = enc_r(rs, rt, rd, 5'd0, FN_SUBU);
            ALU_AND:  word = use_imm ? enc_i(OP_ANDI, rs, rd, imm)  : enc_r(rs, rt, rd, 5'd0, FN_AND);
            ALU_OR:   word = use_imm ? enc_i(OP_ORI, rs, rd, imm)   : enc_r(rs, rt, rd, 5'd0, FN_OR);
            ALU_XOR:  word = use_imm ? enc_i(OP_XORI, rs, rd, imm)  : enc_r(rs, rt, rd, 5'd0, FN_XOR);
            ALU_NOR:  if (use_imm) legal = 1'b0; else word = enc_r(rs, rt, rd, 5'd0, FN_NOR);
            ALU_SLT:  word = use_imm ? enc_i(OP_SLTI, rs, rd, imm)  : enc_r(rs, rt, rd, 5'd0, FN_SLT);
            ALU_SLTU: word = use_imm ? enc_i(OP_SLTIU, rs, rd, imm) : enc_r(rs, rt, rd, 5'd0, FN_SLTU);
            // immediate shifts take shamt from imm[4:0]; variable shifts take the amount from rs
            ALU_SLL:  word = use_imm ? enc_r(5'd0, rt, rd, imm[4:0], FN_SLL) : enc_r(rs, rt, rd, 5'd0, FN_SLLV);
            ALU_SRL:  word = use_imm ? enc_r(5'd0, rt, rd, imm[4:0], FN_SRL) : enc_r(rs, rt, rd, 5'd0, FN_SRLV);
            ALU_SRA:  word = use_imm ? enc_r(5'd0, rt, rd, imm[4:0], FN_SRA) : enc_r(rs, rt, rd, 5'd0, FN_SRAV);
            ALU_LUI:  if (use_imm) word = enc_i(OP_LUI, 5'd0, rd, imm); else legal = 1'b0;
            ALU_SLTI: if (use_imm) word = enc_i(OP_SLTI, rs, rd, imm); else legal = 1'b0;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_inst_enc.sv
// ALU request encoder with a first-word-fall-through output FIFO and a
// saturating counter of dropped (unencodable) requests.
module alu_inst_enc
    import alu_inst_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_alu_op,
    input  logic                     req_use_imm,
    input  logic [4:0]               req_rs,
    input  logic [4:0]               req_rt,
    input  logic [4:0]               req_rd,
    input  logic [15:0]              req_imm,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          legal;
    logic [31:0]   word;
    logic          accept;
    logic          push;
    logic          pop;
    logic          drop;

    alu_inst_enc_comb u_comb (
        .alu_op  (req_alu_op),
        .use_imm (req_use_imm),
        .rs      (req_rs),
        .rt      (req_rt),
        .rd      (req_rd),
        .imm     (req_imm),
        .legal   (legal),
        .word    (word)
    );

    // readiness depends only on occupancy, so a full FIFO never accepts even while popping
    assign req_ready  = (count != (AW+1)'(DEPTH));
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? mem[rd_ptr] : '0;
    assign accept     = req_valid & req_ready;
    assign push       = accept & legal;
    assign drop       = accept & ~legal;
    assign pop        = inst_valid & inst_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= drop;
            if (drop && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_inst_enc.sv
// Scoreboard bench for alu_inst_enc: expected words queued at accept, compared at pop.
module tb_alu_inst_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_alu_op;
    logic        req_use_imm;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [2:0]  count;
    logic        err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    alu_inst_enc #(.DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_alu_op  (req_alu_op),
        .req_use_imm (req_use_imm),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_imm     (req_imm),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .count       (count),
        .err         (err),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pops are decided on the falling edge, where inputs and state are stable.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (sb.size() == 0) check("unexpected_pop", inst, 32'hxxxx_xxxx);
            else check("word", inst, sb.pop_front());
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic use_imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic legal, input logic [31:0] word);
        int n;
        req_alu_op = op; req_use_imm = use_imm; req_rs = rs; req_rt = rt;
        req_rd = rd; req_imm = imm; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (legal) sb.push_back(word);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        inst_ready = 1'b1;
        n = 0;
        while (inst_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_sb"}, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_alu_op = '0; req_use_imm = 1'b0;
        req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; inst_ready = 1'b0;
        #23 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_count", count, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_err", err, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_ready", req_ready, 1);

        // ADDU register form, visible the cycle after accept
        send(4'h0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, 32'h0022_1821);
        check("addu_count", count, 1);
        check("addu_valid", inst_valid, 1);
        check("addu_inst", inst, 32'h0022_1821);
        drain("d1");

        // ADDIU, LUI and immediate SLL stream through in order
        send(4'h0, 1'b1, 5'd5, 5'd0, 5'd9, 16'h0010, 1'b1, 32'h24A9_0010);
        send(4'hB, 1'b1, 5'd3, 5'd0, 5'd7, 16'hBEEF, 1'b1, 32'h3C07_BEEF);
        send(4'h8, 1'b1, 5'd9, 5'd4, 5'd6, 16'h0003, 1'b1, 32'h0004_30C0);
        drain("d2");
        inst_ready = 1'b0;

        // illegal requests: accepted, dropped, flagged
        send(4'h1, 1'b1, 5'd1, 5'd2, 5'd3, 16'h0001, 1'b0, 32'h0);
        check("subu_err", err, 1);
        check("subu_errcnt", err_cnt, 1);
        check("subu_count", count, 0);
        @(posedge clk); #1;
        check("subu_err_pulse", err, 0);
        send(4'hB, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0001, 1'b0, 32'h0);
        check("luir_errcnt", err_cnt, 2);
        send(4'hD, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0001, 1'b0, 32'h0);
        check("undef_errcnt", err_cnt, 3);
        send(4'hC, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0001, 1'b0, 32'h0);
        check("sltir_errcnt", err_cnt, 4);
        for (int i = 0; i < 300; i++)
            send(4'h5, 1'b1, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h0);
        check("sat_errcnt", err_cnt, 255);
        check("sat_count", count, 0);

        // fill to full, single pop, drain
        send(4'hA, 1'b0, 5'd3, 5'd4, 5'd5, 16'h0000, 1'b1, 32'h0064_2807);
        send(4'h3, 1'b1, 5'd2, 5'd0, 5'd8, 16'h1234, 1'b1, 32'h3448_1234);
        send(4'hC, 1'b1, 5'd1, 5'd0, 5'd2, 16'hFFFF, 1'b1, 32'h2822_FFFF);
        send(4'h7, 1'b0, 5'd7, 5'd8, 5'd9, 16'h0000, 1'b1, 32'h00E8_482B);
        check("full_count", count, 4);
        check("full_ready", req_ready, 0);
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
        check("pop1_count", count, 3);
        check("pop1_ready", req_ready, 1);
        drain("d3");
        inst_ready = 1'b0;

        // asynchronous reset between edges flushes everything
        send(4'h0, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'h0021_0821);
        send(4'h0, 1'b0, 5'd2, 5'd2, 5'd2, 16'h0, 1'b1, 32'h0042_1021);
        send(4'h0, 1'b0, 5'd3, 5'd3, 5'd3, 16'h0, 1'b1, 32'h0063_1821);
        check("pre_rst_count", count, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", inst_valid, 0);
        check("arst_count", count, 0);
        check("arst_errcnt", err_cnt, 0);
        sb.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send(4'h4, 1'b0, 5'd10, 5'd11, 5'd12, 16'h0, 1'b1, 32'h014B_6026);
        check("post_rst_inst", inst, 32'h014B_6026);
        drain("d4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
